// File: rtl/host_mem_bridge.sv
// Host-side loader/dumper for the NanoMIPS core: fills data memory from a host byte
// stream, runs the core until done or timeout, then streams a result window back.
module host_mem_bridge #(
    parameter int LOAD_BASE  = 0,
    parameter int LOAD_LEN   = 64,
    parameter int DUMP_BASE  = 64,
    parameter int DUMP_LEN   = 64,
    parameter int MAX_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        mem_owner,
    output logic        cpu_reset,
    input  logic        cpu_done,
    output logic        busy,
    output logic        finished,
    output logic        timeout,
    output logic [15:0] run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CPU_RST = 3'd2,
        S_RUN     = 3'd3,
        S_DUMP    = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam logic [8:0]  LOAD_LAST   = 9'(LOAD_LEN - 1);
    localparam logic [8:0]  DUMP_LAST   = 9'(DUMP_LEN - 1);
    localparam logic [7:0]  LOAD_BASE_A = 8'(LOAD_BASE);
    localparam logic [7:0]  DUMP_BASE_A = 8'(DUMP_BASE);
    localparam logic [15:0] MAX_C       = 16'(MAX_CYCLES);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic [15:0] run_q, run_d;
    logic [15:0] run_inc;
    logic        done_seen;

    assign run_inc = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
    // run_q is still zero only during the first RUN cycle, while core fetch settles
    assign done_seen = cpu_done && (run_q != 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            run_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            run_q     <= run_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        run_d     = run_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    state_d   = S_LOAD;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    run_d     = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == LOAD_LAST) begin
                        state_d = S_CPU_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_CPU_RST: state_d = S_RUN;
            S_RUN: begin
                run_d = run_inc;
                if (done_seen) begin
                    state_d = S_DUMP;
                    cnt_d   = '0;
                end else if (run_inc == MAX_C) begin
                    state_d   = S_DUMP;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            S_DUMP: begin
                if (out_ready) begin
                    if (cnt_q == DUMP_LAST) begin
                        state_d = S_FINISH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_owner = 1'b1;
        cpu_reset = 1'b1;
        busy      = 1'b0;
        finished  = 1'b0;
        case (state_q)
            S_LOAD: begin
                // a reset cycle must not commit a write or acknowledge a byte
                in_ready  = !reset;
                mem_we    = in_valid && !reset;
                mem_addr  = LOAD_BASE_A + cnt_q[7:0];
                mem_wdata = in_data;
                busy      = 1'b1;
            end
            S_CPU_RST: busy = 1'b1;
            S_RUN: begin
                cpu_reset = 1'b0;
                mem_owner = 1'b0;
                busy      = 1'b1;
            end
            S_DUMP: begin
                mem_re    = 1'b1;
                mem_addr  = DUMP_BASE_A + cnt_q[7:0];
                out_data  = mem_rdata;
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            S_FINISH: finished = 1'b1;
            default: ;
        endcase
    end

    assign timeout    = timeout_q;
    assign run_cycles = run_q;

endmodule

// File: tb/tb_host_mem_bridge.sv
// Randomized session bench for host_mem_bridge against a transaction-level model of
// load, run-length/timeout and dump ordering.
module tb_host_mem_bridge;

    localparam int LB   = 0;
    localparam int LLEN = 64;
    localparam int DB   = 64;
    localparam int DLEN = 64;
    localparam int MAXC = 100;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, out_ready, cpu_done;
    logic [7:0]  in_data, mem_rdata;
    logic        in_ready, out_valid, mem_we, mem_re, mem_owner, cpu_reset, busy, finished, timeout;
    logic [7:0]  out_data, mem_addr, mem_wdata;
    logic [15:0] run_cycles;

    logic [7:0]  mem [256];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    host_mem_bridge #(
        .LOAD_BASE(LB), .LOAD_LEN(LLEN), .DUMP_BASE(DB), .DUMP_LEN(DLEN), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_owner(mem_owner), .cpu_reset(cpu_reset),
        .cpu_done(cpu_done), .busy(busy), .finished(finished), .timeout(timeout),
        .run_cycles(run_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: the bench memory commits whatever write the DUT presents at the edge.
    task automatic tick();
        logic       we;
        logic [7:0] a, d;
        we = mem_we; a = mem_addr; d = mem_wdata;
        @(posedge clk);
        if (we === 1'b1) mem[a] = d;
        #1;
    endtask

    // Run length and timeout from the rules: done counts from RUN cycle 2, the limit ends
    // the run at MAXC cycles, and done wins a tie.
    task automatic run_model(input int done_at, output int ex, output bit tout);
        ex = MAXC; tout = 1'b1;
        for (int i = 1; i <= MAXC; i++) begin
            if (done_at != 0 && i >= done_at && i >= 2) begin
                ex = i; tout = 1'b0; return;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cpu_done = 1'b0;
        #1; tick();
        start = 1'b0;
    endtask

    task automatic session(input int vmode, input int rmode, input int done_at,
                           input bit start_in_run, input bit seq_data);
        logic [7:0] d [LLEN];
        logic [7:0] dexp [DLEN];
        int  k, j, cyc, stall, ex, errs;
        bit  v, r, tout;
        for (int i = 0; i < LLEN; i++) d[i] = seq_data ? 8'(i) : 8'($urandom);
        for (int i = 0; i < DLEN; i++) begin
            mem[(DB + i) % 256] = seq_data ? 8'(8'hA0 + i) : 8'($urandom);
            dexp[i] = mem[(DB + i) % 256];
        end
        pulse_start();
        k = 0; cyc = 0;
        while (k < LLEN && cyc < 1000) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom);
            in_valid = v; in_data = d[k];
            #1;
            chk("ld_ready", in_ready, 1);
            chk("ld_busy", busy, 1);
            chk("ld_finished", finished, 0);
            chk("ld_we", mem_we, v);
            chk("ld_cpu_reset", cpu_reset, 1);
            if (v) begin
                chk("ld_addr", mem_addr, (LB + k) % 256);
                chk("ld_wdata", mem_wdata, d[k]);
            end
            tick();
            if (v) k++;
            cyc++;
        end
        if (k < LLEN) begin
            chk("ld_budget", k, LLEN);
            return;
        end
        in_valid = 1'b0;
        #1;
        chk("rst1_cpu_reset", cpu_reset, 1);
        chk("rst1_in_ready", in_ready, 0);
        chk("rst1_owner", mem_owner, 1);
        chk("rst1_busy", busy, 1);
        tick();
        run_model(done_at, ex, tout);
        for (int i = 1; i <= ex; i++) begin
            cpu_done = (done_at != 0 && i >= done_at);
            start = start_in_run && (i == 3);
            #1;
            chk("run_cpu_reset", cpu_reset, 0);
            chk("run_owner", mem_owner, 0);
            chk("run_memctl", {mem_we, mem_re, out_valid}, 0);
            chk("run_busy", busy, 1);
            tick();
            start = 1'b0;
            if (i < ex) chk("run_cycles_live", run_cycles, i);
        end
        cpu_done = 1'b0;
        chk("run_cycles_end", run_cycles, ex);
        chk("timeout_flag", timeout, tout);
        j = 0; cyc = 0; stall = 0;
        while (j < DLEN && cyc < 1000) begin
            if (rmode == 0) r = 1'b1;
            else if (rmode == 1) begin
                r = !(j == 5 && stall < 3);
                if (!r) stall++;
            end else r = 1'($urandom);
            out_ready = r;
            #1;
            chk("dp_valid", out_valid, 1);
            chk("dp_re", mem_re, 1);
            chk("dp_addr", mem_addr, (DB + j) % 256);
            chk("dp_data", out_data, dexp[j]);
            chk("dp_own_rst", {mem_owner, cpu_reset, busy, mem_we}, 4'b1110);
            tick();
            if (r) j++;
            cyc++;
        end
        if (j < DLEN) begin
            chk("dp_budget", j, DLEN);
            return;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("fin_finished", finished, 1);
            chk("fin_busy", busy, 0);
            chk("fin_hs", {out_valid, in_ready, mem_re, mem_we}, 0);
            chk("fin_cpu_reset", cpu_reset, 1);
            chk("fin_timeout", timeout, tout);
            chk("fin_run_cycles", run_cycles, ex);
            tick();
        end
        errs = 0;
        for (int i = 0; i < LLEN; i++) if (mem[(LB + i) % 256] !== d[i]) errs++;
        chk("ld_mem_image", errs, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] keep;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; cpu_done = 1'b0;
        tick(); tick();
        chk("rst_hs", {in_ready, out_valid, mem_we, mem_re}, 0);
        chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
        chk("rst_owner_cpu", {mem_owner, cpu_reset}, 2'b11);
        chk("rst_status", {busy, finished, timeout}, 0);
        chk("rst_run_cycles", run_cycles, 0);
        reset = 1'b0;
        #1; tick();
        chk("idle_busy", busy, 0);

        session(0, 0, 10, 1'b0, 1'b1);    // sequential data, done on RUN cycle 10
        session(1, 1, 20, 1'b1, 1'b0);    // toggled valid, stall at byte 5, start in RUN
        session(2, 2, 0, 1'b1, 1'b0);     // no done: timeout at the limit
        session(0, 2, MAXC, 1'b0, 1'b0);  // done and limit together
        session(2, 0, 1, 1'b0, 1'b0);     // done from cycle 1 is only seen on cycle 2

        // Reset in the middle of a load, with a byte offered in the reset cycle.
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h55 + i);
            #1; tick();
        end
        keep = mem[(LB + 20) % 256];
        in_valid = 1'b1; in_data = ~keep; reset = 1'b1;
        #1;
        chk("midrst_we", mem_we, 0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_status", {busy, finished, timeout}, 0);
        chk("midrst_run_cycles", run_cycles, 0);
        chk("midrst_nowrite", mem[(LB + 20) % 256], keep);
        tick();
        chk("midrst_idle", {busy, mem_owner}, 2'b01);

        session(2, 2, 50, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
